// File: rtl/rv_pkg.sv
// Shared writeback types: register-file geometry and the queued write payload.
// Used by: reg_writeback, wb_fifo.
package rv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  // One pending register-file write.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Pending-write FIFO of wb_entry_t, DEPTH entries (power of two, >= 2).
// Ports:
//   clk, reset          clock, asynchronous active-high reset (pointers/count only)
//   i_push, i_push_data enqueue request and payload (ignored while full)
//   i_pop               dequeue request (ignored while empty)
//   o_head              oldest entry (storage contents; undefined while empty)
//   o_full, o_empty     occupancy flags from the registered count
//   o_count             number of valid entries, 0..DEPTH
//   o_head_ptr, o_mem   raw head pointer and storage, only with REG_WRITEBACK_BYPASS_EN
module wb_fifo
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  wb_entry_t        i_push_data,
  input  logic             i_pop,
  output wb_entry_t        o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
`ifdef REG_WRITEBACK_BYPASS_EN
  ,
  output logic [PTR_W-1:0]      o_head_ptr,
  output wb_entry_t [DEPTH-1:0] o_mem
`endif
);

  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  wb_entry_t [DEPTH-1:0] r_mem;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage is intentionally not reset; validity comes from the count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= i_push_data;
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

`ifdef REG_WRITEBACK_BYPASS_EN
  assign o_head_ptr = r_head;
  assign o_mem      = r_mem;
`endif

endmodule

// File: rtl/reg_writeback.sv
// Register-file writeback stage: arbitrates ALU and load-unit results into a
// pending-write queue and drains it through the single register-file write port.
// Optional feature macro: REG_WRITEBACK_BYPASS_EN (forwarding of queued writes).
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   alu_valid/alu_rd/alu_data       ALU write request; alu_ready accepts it
//   mem_valid/mem_rd/mem_data       load write request (priority); mem_ready accepts it
//   wr_stall                        register-file write port unavailable
//   rd/enable/DataWrite             register-file write port
//   busy                            queue holds at least one pending write
//   rs1/rs2, rsX_hit, rsX_fwd       source lookup into the queue (bypass builds only)
module reg_writeback
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  output logic                  mem_ready,
  input  logic                  wr_stall,
  output logic [REG_ADDR_W-1:0] rd,
  output logic                  enable,
  output logic [XLEN-1:0]       DataWrite,
  output logic                  busy
`ifdef REG_WRITEBACK_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  rs1_hit,
  output logic                  rs2_hit,
  output logic [XLEN-1:0]       rs1_fwd,
  output logic [XLEN-1:0]       rs2_fwd
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  wb_entry_t        w_head;
  wb_entry_t        w_push_data;
  logic             w_mem_acc;
  logic             w_alu_acc;
  logic             w_push;

`ifdef REG_WRITEBACK_BYPASS_EN
  logic [PTR_W-1:0]      w_head_ptr;
  wb_entry_t [DEPTH-1:0] w_mem;
  logic [PTR_W-1:0]      w_slot;
`endif

  // Ready looks only at the registered count, so a same-cycle pop never reopens a full queue.
  assign mem_ready = !w_full;
  assign alu_ready = !w_full && !mem_valid;
  assign w_mem_acc = mem_valid && mem_ready;
  assign w_alu_acc = alu_valid && alu_ready;

  // Load unit wins when both present; only one request is accepted per cycle.
  always_comb begin
    w_push_data.rd   = alu_rd;
    w_push_data.data = alu_data;
    if (mem_valid) begin
      w_push_data.rd   = mem_rd;
      w_push_data.data = mem_data;
    end
  end

  // Writes to x0 complete the handshake but are dropped here.
  assign w_push = (w_mem_acc || w_alu_acc) && (w_push_data.rd != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (enable),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
`ifdef REG_WRITEBACK_BYPASS_EN
    ,
    .o_head_ptr  (w_head_ptr),
    .o_mem       (w_mem)
`endif
  );

  assign enable    = !w_empty && !wr_stall;
  assign rd        = w_empty ? '0 : w_head.rd;
  assign DataWrite = w_empty ? '0 : w_head.data;
  assign busy      = (w_count != '0);

`ifdef REG_WRITEBACK_BYPASS_EN
  // Walk valid entries oldest to youngest so the youngest match is left standing.
  always_comb begin
    rs1_hit = 1'b0;
    rs1_fwd = '0;
    rs2_hit = 1'b0;
    rs2_fwd = '0;
    w_slot  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_slot = w_head_ptr + PTR_W'(k);
      if (CNT_W'(k) < w_count) begin
        if ((rs1 != '0) && (w_mem[w_slot].rd == rs1)) begin
          rs1_hit = 1'b1;
          rs1_fwd = w_mem[w_slot].data;
        end
        if ((rs2 != '0) && (w_mem[w_slot].rd == rs2)) begin
          rs2_hit = 1'b1;
          rs2_fwd = w_mem[w_slot].data;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed vector table, hand-written
// reset/bypass sequences, and randomized traffic against a queue-based model.
module tb_reg_writeback;

  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        wr_stall;
  logic [4:0]  rd;
  logic        enable;
  logic [31:0] DataWrite;
  logic        busy;
`ifdef REG_WRITEBACK_BYPASS_EN
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_hit;
  logic        rs2_hit;
  logic [31:0] rs1_fwd;
  logic [31:0] rs2_fwd;
`endif

  reg_writeback #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .wr_stall  (wr_stall),
    .rd        (rd),
    .enable    (enable),
    .DataWrite (DataWrite),
    .busy      (busy)
`ifdef REG_WRITEBACK_BYPASS_EN
    ,
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1_hit   (rs1_hit),
    .rs2_hit   (rs2_hit),
    .rs1_fwd   (rs1_fwd),
    .rs2_fwd   (rs2_fwd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        st;
    logic        e_ar;
    logic        e_mr;
    logic        e_en;
    logic [4:0]  e_rd;
    logic [31:0] e_dw;
    logic        e_busy;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t model_q[$];
  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                              input logic st, input logic ear, input logic emr, input logic een,
                              input logic [4:0] erd, input logic [31:0] edw, input logic ebusy);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad; v.mv = mv; v.mrd = mrd; v.md = md; v.st = st;
    v.e_ar = ear; v.e_mr = emr; v.e_en = een; v.e_rd = erd; v.e_dw = edw; v.e_busy = ebusy;
    return v;
  endfunction

  // Input-only vector; expectations come from the model.
  function automatic vec_t mi(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                              input logic st);
    return mk(av, ard, ad, mv, mrd, md, st, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
  endfunction

`ifdef REG_WRITEBACK_BYPASS_EN
  // Youngest queued write to a nonzero register.
  task automatic model_lookup(input logic [4:0] rs, output logic hit, output logic [31:0] fwd);
    hit = 1'b0;
    fwd = 32'd0;
    if (rs != 5'd0) begin
      foreach (model_q[i]) begin
        if (model_q[i].rd == rs) begin
          hit = 1'b1;
          fwd = model_q[i].data;
        end
      end
    end
  endtask
`endif

  // Drive one cycle, check outputs mid-cycle, then advance the model at the edge.
  task automatic apply(input vec_t v, input bit use_tab, input string tag);
    logic        e_ar, e_mr, e_en, e_busy;
    logic [4:0]  e_rd;
    logic [31:0] e_dw;
    int          n;
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
    mem_valid = v.mv; mem_rd = v.mrd; mem_data = v.md;
    wr_stall  = v.st;
    @(negedge clk);
    n      = model_q.size();
    e_mr   = (n < int'(DEPTH));
    e_ar   = (n < int'(DEPTH)) && !v.mv;
    e_en   = (n > 0) && !v.st;
    e_rd   = (n > 0) ? model_q[0].rd : 5'd0;
    e_dw   = (n > 0) ? model_q[0].data : 32'd0;
    e_busy = (n > 0);
    if (use_tab) begin
      e_ar = v.e_ar; e_mr = v.e_mr; e_en = v.e_en;
      e_rd = v.e_rd; e_dw = v.e_dw; e_busy = v.e_busy;
    end
    chk({tag, ".alu_ready"}, 32'(alu_ready), 32'(e_ar));
    chk({tag, ".mem_ready"}, 32'(mem_ready), 32'(e_mr));
    chk({tag, ".enable"},    32'(enable),    32'(e_en));
    chk({tag, ".rd"},        32'(rd),        32'(e_rd));
    chk({tag, ".DataWrite"}, DataWrite,      e_dw);
    chk({tag, ".busy"},      32'(busy),      32'(e_busy));
`ifdef REG_WRITEBACK_BYPASS_EN
    begin
      logic        h;
      logic [31:0] f;
      model_lookup(rs1, h, f);
      chk({tag, ".rs1_hit"}, 32'(rs1_hit), 32'(h));
      chk({tag, ".rs1_fwd"}, rs1_fwd, f);
      model_lookup(rs2, h, f);
      chk({tag, ".rs2_hit"}, 32'(rs2_hit), 32'(h));
      chk({tag, ".rs2_fwd"}, rs2_fwd, f);
    end
`endif
    @(posedge clk);
    begin
      ent_t e;
      bit   acc;
      acc = 1'b0;
      if (n > 0 && !v.st) void'(model_q.pop_front());
      if (v.mv && n < int'(DEPTH)) begin
        acc = 1'b1; e.rd = v.mrd; e.data = v.md;
      end else if (v.av && !v.mv && n < int'(DEPTH)) begin
        acc = 1'b1; e.rd = v.ard; e.data = v.ad;
      end
      if (acc && e.rd != 5'd0) model_q.push_back(e);
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    wr_stall = 1'b0;
`ifdef REG_WRITEBACK_BYPASS_EN
    rs1 = '0; rs2 = '0;
`endif

    // Reset state
    #3;
    chk("rst0.enable",    32'(enable),    32'd0);
    chk("rst0.rd",        32'(rd),        32'd0);
    chk("rst0.DataWrite", DataWrite,      32'd0);
    chk("rst0.busy",      32'(busy),      32'd0);
    chk("rst0.alu_ready", 32'(alu_ready), 32'd1);
    chk("rst0.mem_ready", 32'(mem_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors: {av, ard, ad, mv, mrd, md, st} -> {ar, mr, en, rd, DataWrite, busy}
    // single ALU write, one-cycle latency to the write port
    vecs.push_back(mk(1, 5,  32'hDEADBEEF, 0, 0, 0,     0, 1, 1, 0, 0,             0, 0));
    vecs.push_back(mk(0, 0,  0,            0, 0, 0,     0, 1, 1, 1, 5, 32'hDEADBEEF, 1));
    vecs.push_back(mk(0, 0,  0,            0, 0, 0,     0, 1, 1, 0, 0,             0, 0));
    // simultaneous requests: load first, ALU waits
    vecs.push_back(mk(1, 3,  32'h33,       1, 4, 32'h44, 0, 0, 1, 0, 0,        0, 0));
    vecs.push_back(mk(1, 3,  32'h33,       0, 0, 0,     0, 1, 1, 1, 4,     32'h44, 1));
    vecs.push_back(mk(0, 0,  0,            0, 0, 0,     0, 1, 1, 1, 3,     32'h33, 1));
    vecs.push_back(mk(0, 0,  0,            0, 0, 0,     0, 1, 1, 0, 0,          0, 0));
    // stall fills the queue, readies drop, drain in order, then third accepted
    vecs.push_back(mk(1, 10, 32'hA0,       0, 0, 0,     1, 1, 1, 0, 0,          0, 0));
    vecs.push_back(mk(1, 11, 32'hA1,       0, 0, 0,     1, 1, 1, 0, 10,    32'hA0, 1));
    vecs.push_back(mk(1, 12, 32'hA2,       0, 0, 0,     1, 0, 0, 0, 10,    32'hA0, 1));
    vecs.push_back(mk(1, 12, 32'hA2,       0, 0, 0,     1, 0, 0, 0, 10,    32'hA0, 1));
    vecs.push_back(mk(1, 12, 32'hA2,       0, 0, 0,     0, 0, 0, 1, 10,    32'hA0, 1));
    vecs.push_back(mk(1, 12, 32'hA2,       0, 0, 0,     0, 1, 1, 1, 11,    32'hA1, 1));
    vecs.push_back(mk(0, 0,  0,            0, 0, 0,     0, 1, 1, 1, 12,    32'hA2, 1));
    vecs.push_back(mk(0, 0,  0,            0, 0, 0,     0, 1, 1, 0, 0,          0, 0));
    // x0 writes are consumed but never queued
    vecs.push_back(mk(1, 0,  32'h1234,     0, 0, 0,     0, 1, 1, 0, 0,          0, 0));
    vecs.push_back(mk(0, 0,  0,            0, 0, 0,     0, 1, 1, 0, 0,          0, 0));
    vecs.push_back(mk(0, 0,  0,            1, 0, 32'h55, 0, 0, 1, 0, 0,         0, 0));
    vecs.push_back(mk(0, 0,  0,            0, 0, 0,     0, 1, 1, 0, 0,          0, 0));
    // back-to-back writes to the same register are both issued
    vecs.push_back(mk(1, 7,  32'h1,        0, 0, 0,     0, 1, 1, 0, 0,          0, 0));
    vecs.push_back(mk(1, 7,  32'h2,        0, 0, 0,     0, 1, 1, 1, 7,        32'h1, 1));
    vecs.push_back(mk(0, 0,  0,            0, 0, 0,     0, 1, 1, 1, 7,        32'h2, 1));
    vecs.push_back(mk(0, 0,  0,            0, 0, 0,     0, 1, 1, 0, 0,          0, 0));
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], 1'b1, $sformatf("v%0d", i));

`ifdef REG_WRITEBACK_BYPASS_EN
    // Forwarding: the entry being accepted is not visible; youngest match wins.
    rs1 = 5'd7; rs2 = 5'd0;
    apply(mi(1, 7, 32'h11, 0, 0, 0, 1), 1'b0, "byp.push0");
    apply(mi(1, 7, 32'h22, 0, 0, 0, 1), 1'b0, "byp.push1");
    alu_valid = 1'b0; wr_stall = 1'b1;
    @(negedge clk);
    chk("byp.rs1_hit", 32'(rs1_hit), 32'd1);
    chk("byp.rs1_fwd", rs1_fwd,      32'h22);
    chk("byp.rs2_hit", 32'(rs2_hit), 32'd0);
    chk("byp.rs2_fwd", rs2_fwd,      32'd0);
    @(posedge clk);
    #1;
    repeat (3) apply(mi(0, 0, 0, 0, 0, 0, 0), 1'b0, "byp.drain");
    rs1 = '0;
`endif

    // Reset with two entries pending drops them immediately
    apply(mi(1, 8, 32'h80, 0, 0, 0, 1), 1'b0, "mid.push0");
    apply(mi(1, 9, 32'h90, 0, 0, 0, 1), 1'b0, "mid.push1");
    alu_valid = 1'b0;
    wr_stall  = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("mid.enable",    32'(enable),    32'd0);
    chk("mid.busy",      32'(busy),      32'd0);
    chk("mid.rd",        32'(rd),        32'd0);
    chk("mid.DataWrite", DataWrite,      32'd0);
    chk("mid.alu_ready", 32'(alu_ready), 32'd1);
    chk("mid.mem_ready", 32'(mem_ready), 32'd1);
    model_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (4) apply(mi(0, 0, 0, 0, 0, 0, 0), 1'b0, "mid.after");

    // Randomized traffic against the queue model
    for (int c = 0; c < 400; c++) begin
      vec_t v;
      v = mi(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 9) < 3));
`ifdef REG_WRITEBACK_BYPASS_EN
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
`endif
      apply(v, 1'b0, $sformatf("rnd%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
